// File: rtl/seq_detector.sv
// Serial bit-pattern detector: tracks the longest matched prefix of PATTERN
// (KMP style) and flags a hit when the final pattern bit arrives.
module seq_detector #(
  parameter int                     PATTERN_LEN = 4,
  parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
  parameter bit                     OVERLAP     = 1'b1,
  parameter bit                     MOORE       = 1'b0,
  parameter int                     CNT_W       = 8,
  localparam int                    SW          = ($clog2(PATTERN_LEN) < 1) ? 1 : $clog2(PATTERN_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             x,
  output logic             y,
  output logic [SW-1:0]    state,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // Longest pattern prefix (at most L-1 bits) that ends the stream formed by
  // the k-bit matched prefix followed by xb; bit 0 of hist is the newest bit.
  function automatic logic [SW-1:0] kmp_next(input logic [SW-1:0] k, input logic xb);
    logic [31:0] pat;
    logic [31:0] hist;
    logic [31:0] mask;
    int          kk;
    int          best;
    pat  = 32'(PATTERN);
    kk   = int'(k);
    hist = ((pat >> (PATTERN_LEN - kk)) << 1) | 32'(xb);
    best = 0;
    for (int j = 1; j < PATTERN_LEN; j++) begin
      mask = (32'd1 << j) - 32'd1;
      if ((j <= kk + 1) && ((hist & mask) == (pat >> (PATTERN_LEN - j)))) begin
        best = j;
      end else begin
        best = best;
      end
    end
    return SW'(best);
  endfunction

  localparam logic [SW-1:0] LAST_ST  = SW'(PATTERN_LEN - 1);
  localparam logic [SW-1:0] HIT_NEXT = OVERLAP ? kmp_next(LAST_ST, PATTERN[0]) : {SW{1'b0}};

  logic [SW-1:0]    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             y_q, y_d;
  logic             hit_s;

  assign hit_s = en && (state_q == LAST_ST) && (x == PATTERN[0]);

  // Next-state, counter and Moore flag; clr overrides any hit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    if (clr) begin
      state_d = {SW{1'b0}};
      cnt_d   = {CNT_W{1'b0}};
      y_d     = 1'b0;
    end else if (en) begin
      y_d = hit_s;
      if (hit_s) begin
        state_d = HIT_NEXT;
        if (&cnt_q) begin
          cnt_d = cnt_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        state_d = kmp_next(state_q, x);
      end
    end else begin
      state_d = state_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= {SW{1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign y         = MOORE ? y_q : (hit_s & rst_n);
  assign state     = state_q;
  assign match_cnt = cnt_q;
  assign cnt_sat   = &cnt_q;

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: four configurations share one stimulus bus.
module tb_seq_detector;

  logic clk, rst_n, clr, en, x;

  logic       y_a, sat_a, y_b, sat_b, y_c, sat_c, y_d, sat_d;
  logic [1:0] st_a, st_b, st_c, st_d;
  logic [7:0] cnt_a, cnt_b, cnt_c;
  logic [1:0] cnt_d;

  int vectors = 0;
  int miscompares = 0;

  seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x),
    .y(y_a), .state(st_a), .match_cnt(cnt_a), .cnt_sat(sat_a));

  seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b0), .MOORE(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x),
    .y(y_b), .state(st_b), .match_cnt(cnt_b), .cnt_sat(sat_b));

  seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1111), .OVERLAP(1'b1), .MOORE(1'b1), .CNT_W(8)) dut_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x),
    .y(y_c), .state(st_c), .match_cnt(cnt_c), .cnt_sat(sat_c));

  seq_detector #(.PATTERN_LEN(4), .PATTERN(4'b1011), .OVERLAP(1'b1), .MOORE(1'b0), .CNT_W(2)) dut_d (
    .clk(clk), .rst_n(rst_n), .clr(clr), .en(en), .x(x),
    .y(y_d), .state(st_d), .match_cnt(cnt_d), .cnt_sat(sat_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic xb, input logic eb, input logic cb);
    @(negedge clk);
    x = xb; en = eb; clr = cb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0]  s1;
    logic [6:0]  ey_a, ey_b;
    logic [15:0] s5;
    logic [5:0]  s6;
    int          st_a_exp[7];
    int          st_b_exp[7];
    int          hits;
    logic        b;

    s1 = 7'b1011011;
    ey_a = 7'b0001001;
    ey_b = 7'b0001000;
    st_a_exp = '{1, 2, 3, 1, 2, 3, 1};
    st_b_exp = '{1, 2, 3, 0, 0, 1, 1};
    s5 = 16'b1011011011011011;
    s6 = 6'b101101;

    rst_n = 1'b0; x = 1'b0; en = 1'b0; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.a.state", st_a, 0);
    chk("rst.a.cnt", cnt_a, 0);
    chk("rst.a.sat", sat_a, 0);
    chk("rst.a.y", y_a, 0);
    chk("rst.c.y", y_c, 0);
    chk("rst.d.cnt", cnt_d, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Stream 1011011: overlapping vs non-overlapping
    for (int i = 0; i < 7; i++) begin
      b = s1[6-i];
      drive(b, 1'b1, 1'b0);
      chk($sformatf("s1.a.y[%0d]", i), y_a, ey_a[6-i]);
      chk($sformatf("s1.b.y[%0d]", i), y_b, ey_b[6-i]);
      tick();
      chk($sformatf("s1.a.state[%0d]", i), st_a, st_a_exp[i]);
      chk($sformatf("s1.b.state[%0d]", i), st_b, st_b_exp[i]);
    end
    chk("s1.a.cnt", cnt_a, 2);
    chk("s1.b.cnt", cnt_b, 1);

    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("clr.a.state", st_a, 0);
    chk("clr.a.cnt", cnt_a, 0);
    chk("clr.b.cnt", cnt_b, 0);

    // Moore 1111 with six ones, then a hold and a break
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      chk($sformatf("moore.c.y_pre[%0d]", i), y_c, (i >= 5) ? 1 : 0);
      tick();
      chk($sformatf("moore.c.y[%0d]", i), y_c, (i >= 4) ? 1 : 0);
      chk($sformatf("moore.c.state[%0d]", i), st_c, (i >= 3) ? 3 : i);
    end
    chk("moore.c.cnt", cnt_c, 3);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    chk("moore.c.y_hold", y_c, 1);
    chk("moore.c.state_hold", st_c, 3);
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("moore.c.y_drop", y_c, 0);
    chk("moore.c.state_break", st_c, 0);

    // Hit coinciding with clr on the Moore instance
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0);
      tick();
    end
    chk("clrhit.c.state_pre", st_c, 3);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    chk("clrhit.c.y", y_c, 0);
    chk("clrhit.c.cnt", cnt_c, 0);
    chk("clrhit.c.state", st_c, 0);

    // Enable gaps on the Mealy instance
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    chk("gap.a.state_pre", st_a, 2);
    for (int i = 0; i < 3; i++) begin
      drive(~i[0], 1'b0, 1'b0);
      chk($sformatf("gap.a.y[%0d]", i), y_a, 0);
      tick();
      chk($sformatf("gap.a.state[%0d]", i), st_a, 2);
    end
    drive(1'b1, 1'b1, 1'b0);
    chk("gap.a.y3", y_a, 0);
    tick();
    chk("gap.a.state3", st_a, 3);
    drive(1'b1, 1'b0, 1'b0);
    chk("gap.a.y_disabled_last", y_a, 0);
    tick();
    chk("gap.a.state_hold3", st_a, 3);
    chk("gap.a.cnt_hold", cnt_a, 0);
    drive(1'b1, 1'b1, 1'b0);
    chk("gap.a.y_hit", y_a, 1);
    tick();
    chk("gap.a.state_hit", st_a, 1);
    chk("gap.a.cnt_hit", cnt_a, 1);

    // Saturating 2-bit counter over five overlapping matches
    drive(1'b0, 1'b1, 1'b1);
    tick();
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      b = s5[15-i];
      drive(b, 1'b1, 1'b0);
      if (i >= 3 && (i % 3) == 0) begin
        chk($sformatf("sat.d.y[%0d]", i), y_d, 1);
        tick();
        hits++;
        chk($sformatf("sat.d.cnt[%0d]", hits), cnt_d, (hits > 3) ? 3 : hits);
        chk($sformatf("sat.d.sat[%0d]", hits), sat_d, (hits >= 3) ? 1 : 0);
      end else begin
        tick();
      end
    end
    drive(1'b0, 1'b1, 1'b1);
    tick();
    chk("sat.d.cnt_clr", cnt_d, 0);
    chk("sat.d.sat_clr", sat_d, 0);
    chk("sat.d.state_clr", st_d, 0);

    // Asynchronous reset in the middle of a pattern
    for (int i = 0; i < 6; i++) begin
      b = s6[5-i];
      drive(b, 1'b1, 1'b0);
      tick();
    end
    chk("arst.a.state_pre", st_a, 3);
    chk("arst.a.cnt_pre", cnt_a, 1);
    x = 1'b1; en = 1'b1;
    #1;
    chk("arst.a.y_pre", y_a, 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst.a.y", y_a, 0);
    chk("arst.a.state", st_a, 0);
    chk("arst.a.cnt", cnt_a, 0);
    chk("arst.a.sat", sat_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst.a.y_first", y_a, 0);
    tick();
    chk("arst.a.state_first", st_a, 1);
    chk("arst.a.cnt_first", cnt_a, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
